// File: rtl/sample_delay_line.sv
// Multi-channel delay line with stall, valid tracking, per-channel change
// detection, PASS/TOGGLE/HOLD output modes and a wrapping valid-sample counter.
module sample_delay_line #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        en,
    input  logic                        clr,
    input  logic [1:0]                  mode,
    input  logic                        in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic                        out_valid,
    output logic [CHANNELS*WIDTH-1:0]   out_data,
    output logic [CHANNELS-1:0]         out_change,
    output logic [CNT_W-1:0]            sample_cnt,
    output logic                        cnt_wrap
);

    localparam int DW = CHANNELS * WIDTH;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    // Data and valid presented to the output stage
    logic [DW-1:0] stg_data;
    logic          stg_vld;

    if (DEPTH > 1) begin : g_shift
        localparam int NS = DEPTH - 1;

        logic [DW-1:0] sh_data_q [NS];
        logic [DW-1:0] sh_data_d [NS];
        logic [NS-1:0] sh_vld_q;
        logic [NS-1:0] sh_vld_d;

        // Shift stages S1..S(DEPTH-1) advance on en regardless of mode
        always_comb begin
            sh_data_d = sh_data_q;
            sh_vld_d  = sh_vld_q;
            if (en) begin
                sh_data_d[0] = in_data;
                sh_vld_d[0]  = in_valid;
                for (int k = 1; k < NS; k++) begin
                    sh_data_d[k] = sh_data_q[k-1];
                    sh_vld_d[k]  = sh_vld_q[k-1];
                end
            end
        end

        // Shift stage registers
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int k = 0; k < NS; k++) begin
                    sh_data_q[k] <= '0;
                end
                sh_vld_q <= '0;
            end else begin
                sh_data_q <= sh_data_d;
                sh_vld_q  <= sh_vld_d;
            end
        end

        assign stg_data = sh_data_q[NS-1];
        assign stg_vld  = sh_vld_q[NS-1];
    end else begin : g_direct
        // Single-stage line: the output stage samples the inputs directly
        assign stg_data = in_data;
        assign stg_vld  = in_valid;
    end

    logic [DW-1:0]       out_data_q,   out_data_d;
    logic                out_valid_q,  out_valid_d;
    logic [CHANNELS-1:0] out_change_q, out_change_d;
    logic [DW-1:0]       ref_q,        ref_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic                cnt_wrap_q,   cnt_wrap_d;

    // Output stage, reference register and counter next-state
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_change_d = out_change_q;
        ref_d        = ref_q;
        sample_cnt_d = sample_cnt_q;
        cnt_wrap_d   = cnt_wrap_q;

        if (en) begin
            if (mode == MODE_HOLD) begin
                // Output and reference freeze; arriving samples are dropped
                out_valid_d  = 1'b0;
                out_change_d = '0;
            end else begin
                out_valid_d = stg_vld;
                if (stg_vld) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        out_change_d[c] = (stg_data[c*WIDTH +: WIDTH] != ref_q[c*WIDTH +: WIDTH]);
                    end
                    ref_d      = stg_data;
                    out_data_d = (mode == MODE_TOGGLE) ? (stg_data ^ ref_q) : stg_data;
                end else begin
                    out_change_d = '0;
                    out_data_d   = (mode == MODE_TOGGLE) ? '0 : stg_data;
                end
            end

            if (out_valid_d) begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
                if (&sample_cnt_q) begin
                    cnt_wrap_d = 1'b1;
                end
            end
        end

        // Clear overrides any increment or wrap, even while stalled
        if (clr) begin
            sample_cnt_d = '0;
            cnt_wrap_d   = 1'b0;
        end
    end

    // Output stage registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_change_q <= '0;
            ref_q        <= '0;
            sample_cnt_q <= '0;
            cnt_wrap_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_change_q <= out_change_d;
            ref_q        <= ref_d;
            sample_cnt_q <= sample_cnt_d;
            cnt_wrap_q   <= cnt_wrap_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_change = out_change_q;
    assign sample_cnt = sample_cnt_q;
    assign cnt_wrap   = cnt_wrap_q;

endmodule

// File: tb/tb_sample_delay_line.sv
// Scoreboard bench for sample_delay_line: a DEPTH=3, 2x4-bit, CNT_W=2 line
// and a DEPTH=1, 1-bit toggle line.
module tb_sample_delay_line;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=3, WIDTH=4, CHANNELS=2, CNT_W=2
    logic       en_a = 1'b0, clr_a = 1'b0, iv_a = 1'b0;
    logic [1:0] mode_a = 2'b00;
    logic [7:0] id_a = 8'h00;
    logic       ov_a, wrap_a;
    logic [7:0] od_a;
    logic [1:0] ch_a, cnt_a;

    sample_delay_line #(.WIDTH(4), .CHANNELS(2), .DEPTH(3), .CNT_W(2)) u_a (
        .CLK(clk), .RST_N(rst_n), .en(en_a), .clr(clr_a), .mode(mode_a),
        .in_valid(iv_a), .in_data(id_a), .out_valid(ov_a), .out_data(od_a),
        .out_change(ch_a), .sample_cnt(cnt_a), .cnt_wrap(wrap_a));

    // Instance B: DEPTH=1, WIDTH=1, CHANNELS=1, CNT_W=16
    logic        en_b = 1'b0, clr_b = 1'b0, iv_b = 1'b0;
    logic [1:0]  mode_b = 2'b00;
    logic        id_b = 1'b0;
    logic        ov_b, wrap_b, od_b, ch_b;
    logic [15:0] cnt_b;

    sample_delay_line #(.WIDTH(1), .CHANNELS(1), .DEPTH(1), .CNT_W(16)) u_b (
        .CLK(clk), .RST_N(rst_n), .en(en_b), .clr(clr_b), .mode(mode_b),
        .in_valid(iv_b), .in_data(id_b), .out_valid(ov_b), .out_data(od_b),
        .out_change(ch_b), .sample_cnt(cnt_b), .cnt_wrap(wrap_b));

    typedef struct packed { logic [7:0] d; logic [1:0] ch; logic [1:0] cnt; } exp_a_t;
    typedef struct packed { logic d; logic ch; logic [15:0] cnt; } exp_b_t;

    exp_a_t q_a[$];
    exp_b_t q_b[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whether the most recent rising edge was an advancing one
    logic adv_a = 1'b0, adv_b = 1'b0;
    always @(posedge clk) begin
        adv_a <= en_a;
        adv_b <= en_b;
    end

    // Monitor A: every newly emitted valid sample is checked against the queue
    always @(negedge clk) begin
        if (rst_n && adv_a && ov_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_sample", {24'h0, od_a}, 32'hFFFF_FFFF);
            end else begin
                exp_a_t e;
                e = q_a.pop_front();
                chk("a_out_data", {24'h0, od_a}, {24'h0, e.d});
                chk("a_out_change", {30'h0, ch_a}, {30'h0, e.ch});
                chk("a_sample_cnt", {30'h0, cnt_a}, {30'h0, e.cnt});
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (rst_n && adv_b && ov_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_sample", {31'h0, od_b}, 32'hFFFF_FFFF);
            end else begin
                exp_b_t e;
                e = q_b.pop_front();
                chk("b_out_data", {31'h0, od_b}, {31'h0, e.d});
                chk("b_out_change", {31'h0, ch_b}, {31'h0, e.ch});
                chk("b_sample_cnt", {16'h0, cnt_b}, {16'h0, e.cnt});
            end
        end
    end

    task automatic drv_a(input logic v, input logic [7:0] d);
        iv_a = v;
        id_a = d;
        @(negedge clk);
    endtask

    task automatic drv_b(input logic v, input logic d);
        iv_b = v;
        id_b = d;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_valid", {31'h0, ov_a}, 0);
        chk("rst_a_data", {24'h0, od_a}, 0);
        chk("rst_a_cnt", {30'h0, cnt_a}, 0);
        chk("rst_a_wrap", {31'h0, wrap_a}, 0);
        chk("rst_b_valid", {31'h0, ov_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // B: toggle mode, inputs 0,1,1,0
        en_b = 1'b1;
        mode_b = 2'b01;
        q_b.push_back('{d: 1'b0, ch: 1'b0, cnt: 16'd1}); drv_b(1'b1, 1'b0);
        q_b.push_back('{d: 1'b1, ch: 1'b1, cnt: 16'd2}); drv_b(1'b1, 1'b1);
        q_b.push_back('{d: 1'b0, ch: 1'b0, cnt: 16'd3}); drv_b(1'b1, 1'b1);
        q_b.push_back('{d: 1'b1, ch: 1'b1, cnt: 16'd4}); drv_b(1'b1, 1'b0);
        drv_b(1'b0, 1'b1);
        chk("b_toggle_bubble_data", {31'h0, od_b}, 0);
        chk("b_toggle_bubble_valid", {31'h0, ov_b}, 0);
        en_b = 1'b0;

        // A: single sample then bubbles
        en_a = 1'b1;
        mode_a = 2'b00;
        q_a.push_back('{d: 8'hA5, ch: 2'b11, cnt: 2'd1}); drv_a(1'b1, 8'hA5);
        repeat (4) drv_a(1'b0, 8'h00);
        chk("a_cnt_after_first", {30'h0, cnt_a}, 1);

        // A: back-to-back stream, counter wraps on the fourth emit
        q_a.push_back('{d: 8'h11, ch: 2'b11, cnt: 2'd2}); drv_a(1'b1, 8'h11);
        q_a.push_back('{d: 8'h11, ch: 2'b00, cnt: 2'd3}); drv_a(1'b1, 8'h11);
        q_a.push_back('{d: 8'h21, ch: 2'b10, cnt: 2'd0}); drv_a(1'b1, 8'h21);
        repeat (3) drv_a(1'b0, 8'h00);
        chk("a_wrap_set", {31'h0, wrap_a}, 1);
        chk("a_cnt_wrapped", {30'h0, cnt_a}, 0);
        q_a.push_back('{d: 8'h21, ch: 2'b00, cnt: 2'd1}); drv_a(1'b1, 8'h21);
        repeat (3) drv_a(1'b0, 8'h00);
        chk("a_wrap_sticky", {31'h0, wrap_a}, 1);

        // A: clr on the same edge as a valid emit
        q_a.push_back('{d: 8'h3C, ch: 2'b11, cnt: 2'd0}); drv_a(1'b1, 8'h3C);
        drv_a(1'b0, 8'h00);
        clr_a = 1'b1;
        drv_a(1'b0, 8'h00);
        clr_a = 1'b0;
        chk("a_clr_wrap", {31'h0, wrap_a}, 0);
        chk("a_clr_valid_emit", {31'h0, ov_a}, 1);

        // A: four-cycle stall mid-stream
        q_a.push_back('{d: 8'h5A, ch: 2'b11, cnt: 2'd1}); drv_a(1'b1, 8'h5A);
        en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv_a(1'b1, 8'hFF);
            chk("a_stall_valid", {31'h0, ov_a}, 0);
            chk("a_stall_data", {24'h0, od_a}, 0);
            chk("a_stall_cnt", {30'h0, cnt_a}, 0);
        end
        en_a = 1'b1;
        drv_a(1'b0, 8'h00);
        chk("a_stall_latency", {31'h0, ov_a}, 0);
        drv_a(1'b0, 8'h00);
        chk("a_stall_emerged", {31'h0, ov_a}, 1);

        // A: HOLD for three advancing edges, then back to PASS
        q_a.push_back('{d: 8'h01, ch: 2'b11, cnt: 2'd2}); drv_a(1'b1, 8'h01);
        drv_a(1'b1, 8'h02);
        drv_a(1'b1, 8'h03);
        mode_a = 2'b10;
        q_a.push_back('{d: 8'h05, ch: 2'b01, cnt: 2'd3});
        for (int i = 0; i < 3; i++) begin
            drv_a(1'b1, 8'h04 + 8'(i));
            chk("a_hold_valid", {31'h0, ov_a}, 0);
            chk("a_hold_data", {24'h0, od_a}, 32'h01);
            chk("a_hold_change", {30'h0, ch_a}, 0);
            chk("a_hold_cnt", {30'h0, cnt_a}, 2);
        end
        mode_a = 2'b00;
        q_a.push_back('{d: 8'h06, ch: 2'b01, cnt: 2'd0});
        q_a.push_back('{d: 8'h07, ch: 2'b01, cnt: 2'd1}); drv_a(1'b1, 8'h07);
        repeat (3) drv_a(1'b0, 8'h00);

        // A: toggle mode on a multi-channel line, bubble forces zero output
        mode_a = 2'b01;
        q_a.push_back('{d: 8'h08, ch: 2'b01, cnt: 2'd2}); drv_a(1'b1, 8'h0F);
        repeat (3) drv_a(1'b0, 8'hEE);
        chk("a_toggle_bubble_data", {24'h0, od_a}, 0);
        chk("a_toggle_bubble_valid", {31'h0, ov_a}, 0);

        // A: asynchronous reset mid-stream discards in-flight samples
        mode_a = 2'b00;
        drv_a(1'b1, 8'h33);
        drv_a(1'b1, 8'h34);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, ov_a}, 0);
        chk("arst_data", {24'h0, od_a}, 0);
        chk("arst_change", {30'h0, ch_a}, 0);
        chk("arst_cnt", {30'h0, cnt_a}, 0);
        chk("arst_wrap", {31'h0, wrap_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q_a.push_back('{d: 8'h44, ch: 2'b11, cnt: 2'd1}); drv_a(1'b1, 8'h44);
        repeat (4) drv_a(1'b0, 8'h00);

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
